// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative signed multiply / divide engine placed between the Y register
//   (operand A) and the bus (operand B). The 2*WIDTH-bit result is offered on
//   z_hi/z_lo for loading into ZHI/ZLO.
//   Multiply: radix-2 Booth, one step per cycle.
//   Divide  : non-restoring division on magnitudes, with sign correction in
//             a final fix-up cycle (quotient truncates toward zero, remainder
//             carries the sign of the dividend).
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset
//   start      request a new operation (honoured only when not busy)
//   op         0 = signed multiply, 1 = signed divide
//   operand_a  multiplicand / dividend
//   operand_b  multiplier / divisor
//   busy       operation in progress
//   done       one-cycle result-valid pulse
//   div_zero   last divide had divisor 0 (valid with done, held)
//   z_hi       mul: product high half; div: remainder
//   z_lo       mul: product low half;  div: quotient
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;  // accumulator: two guard bits for Booth/divide headroom

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [AW-1:0]    acc;       // Booth partial product / divide partial remainder
  logic [WIDTH-1:0] qreg;      // Booth multiplier / divide quotient shift register
  logic             q_m1;      // Booth extra bit q(-1)
  logic [WIDTH-1:0] mreg;      // multiplicand (signed) or |divisor| (unsigned)
  logic [WIDTH-1:0] a_hold;    // original dividend, returned on divide-by-zero
  logic             op_div;
  logic             a_neg;
  logic             q_neg;
  logic             b_zero;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    m_uns;
  logic [AW-1:0]    booth_sum;
  logic [AW-1:0]    booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [AW-1:0]    div_shift;
  logic [AW-1:0]    div_acc;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and start acceptance.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = (cnt == CW'(WIDTH - 1));
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          accept     = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_next = S_FIX;
        end else begin
          state_next = S_RUN;
        end
      end
      S_FIX: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        // Allows back-to-back operations without an idle cycle.
        if (start) begin
          state_next = S_RUN;
          accept     = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    if (operand_a[WIDTH-1]) begin
      a_abs = -operand_a;
    end else begin
      a_abs = operand_a;
    end
    if (operand_b[WIDTH-1]) begin
      b_abs = -operand_b;
    end else begin
      b_abs = operand_b;
    end
  end

  // One radix-2 Booth step: add/subtract multiplicand, then arithmetic shift right.
  always_comb begin
    m_ext = {{2{mreg[WIDTH-1]}}, mreg};
    case ({qreg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[AW-1], booth_sum[AW-1:1]};
    booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};
  end

  // One non-restoring step: shift left, subtract or add |divisor| by remainder sign.
  always_comb begin
    m_uns     = {2'b00, mreg};
    div_shift = {acc[AW-2:0], qreg[WIDTH-1]};
    if (acc[AW-1]) begin
      div_acc = div_shift + m_uns;
    end else begin
      div_acc = div_shift - m_uns;
    end
    div_q = {qreg[WIDTH-2:0], ~div_acc[AW-1]};
  end

  // Final divide correction: restore a negative remainder, then apply signs.
  // The restored remainder lies in [0, |b|), so WIDTH-bit arithmetic suffices.
  always_comb begin
    if (acc[AW-1]) begin
      rem_mag = acc[WIDTH-1:0] + mreg;
    end else begin
      rem_mag = acc[WIDTH-1:0];
    end
    if (q_neg) begin
      quot_fix = -qreg;
    end else begin
      quot_fix = qreg;
    end
    if (a_neg) begin
      rem_fix = -rem_mag;
    end else begin
      rem_fix = rem_mag;
    end
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc      <= {AW{1'b0}};
      qreg     <= {WIDTH{1'b0}};
      q_m1     <= 1'b0;
      mreg     <= {WIDTH{1'b0}};
      a_hold   <= {WIDTH{1'b0}};
      op_div   <= 1'b0;
      a_neg    <= 1'b0;
      q_neg    <= 1'b0;
      b_zero   <= 1'b0;
      cnt      <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      z_hi     <= {WIDTH{1'b0}};
      z_lo     <= {WIDTH{1'b0}};
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (accept) begin
            busy   <= 1'b1;
            cnt    <= {CW{1'b0}};
            op_div <= op;
            a_hold <= operand_a;
            acc    <= {AW{1'b0}};
            q_m1   <= 1'b0;
            a_neg  <= operand_a[WIDTH-1];
            q_neg  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            b_zero <= (operand_b == {WIDTH{1'b0}});
            if (op) begin
              qreg <= a_abs;
              mreg <= b_abs;
            end else begin
              qreg <= operand_b;
              mreg <= operand_a;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            acc  <= div_acc;
            qreg <= div_q;
          end else begin
            acc  <= booth_acc;
            qreg <= booth_q;
            q_m1 <= qreg[0];
          end
        end
        S_FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!op_div) begin
            z_hi     <= acc[WIDTH-1:0];
            z_lo     <= qreg;
            div_zero <= 1'b0;
          end else if (b_zero) begin
            z_hi     <= a_hold;
            z_lo     <= {WIDTH{1'b1}};
            div_zero <= 1'b1;
          end else begin
            z_hi     <= rem_fix;
            z_lo     <= quot_fix;
            div_zero <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed, table-driven bench for mul_div_unit (WIDTH=32): a vector table
//   of operands with hand-computed results, plus hand-written sequences for
//   ignored start, asynchronous reset mid-operation and back-to-back issue.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] z_hi;
  logic [31:0] z_lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[16];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .z_hi      (z_hi),
    .z_lo      (z_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (from posedge+1) for done; n = edges waited, -1 on timeout.
  // bc accumulates busy samples seen before done.
  task automatic wait_done(output int n, inout int bc);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
      bc += int'(busy);
    end
  endtask

  // Issue one operation from posedge+1 and wait for its result.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    bc = int'(busy);
    wait_done(lat, bc);
  endtask

  initial begin
    int lat;
    int bc;
    int n1;
    int n2;
    int seen;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFEF, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFEF, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0007, 32'h0000_0009, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1};
    vecs[13] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[15] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000, 1'b0};

    clr = 1'b1; start = 1'b0; op = 1'b0; operand_a = 32'h0; operand_b = 32'h0;
    #12;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_div_zero", {63'h0, div_zero}, 64'h0);
    check("reset_z", {z_hi, z_lo}, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd33);
      check($sformatf("v%0d_busy_at_done", i), {63'h0, busy}, 64'h0);
      check($sformatf("v%0d_z_hi", i), {32'h0, z_hi}, {32'h0, vecs[i].hi});
      check($sformatf("v%0d_z_lo", i), {32'h0, z_lo}, {32'h0, vecs[i].lo});
      check($sformatf("v%0d_div_zero", i), {63'h0, div_zero}, {63'h0, vecs[i].dz});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), {63'h0, done}, 64'h0);
      check($sformatf("v%0d_z_hold", i), {z_hi, z_lo}, {vecs[i].hi, vecs[i].lo});
    end

    // Start pulse while busy is ignored.
    start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = 1'b1; operand_a = 32'd99; operand_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0;
    wait_done(lat, bc);
    check("ignored_start_latency", 64'(lat), 64'd28);
    check("ignored_start_z_lo", {32'h0, z_lo}, 64'h0000_000C);
    check("ignored_start_z_hi", {32'h0, z_hi}, 64'h0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; op = 1'b0; operand_a = 32'd5; operand_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    #2;
    clr = 1'b1;
    #1;
    check("clr_busy", {63'h0, busy}, 64'h0);
    check("clr_done", {63'h0, done}, 64'h0);
    check("clr_z", {z_hi, z_lo}, 64'h0);
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen += int'(done) + int'(busy);
    end
    check("clr_no_done_40", 64'(seen), 64'd0);

    // Back-to-back: start held high, operands switched after first accept.
    start = 1'b1; op = 1'b0; operand_a = 32'd2; operand_b = 32'd3;
    @(posedge clk); #1;
    op = 1'b1; operand_a = 32'd9; operand_b = 32'd2;
    bc = 0;
    wait_done(n1, bc);
    check("b2b_first_latency", 64'(n1), 64'd33);
    check("b2b_first_z_lo", {32'h0, z_lo}, 64'd6);
    check("b2b_first_z_hi", {32'h0, z_hi}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", {63'h0, busy}, 64'h1);
    bc = 0;
    wait_done(n2, bc);
    check("b2b_done_gap", 64'((n2 < 0) ? -1 : n2 + 1), 64'd34);
    check("b2b_second_q", {32'h0, z_lo}, 64'd4);
    check("b2b_second_r", {32'h0, z_hi}, 64'd1);
    check("b2b_second_dz", {63'h0, div_zero}, 64'h0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
